// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage feeding the decoder. Holds the fetch PC, issues
//   single-outstanding word reads on the imem request/ack bus, buffers returned
//   words in a small {pc, instr} FIFO and presents the head to the decoder.
//   Honours decoder stall and branch redirect (flush + restart).
//
// Configuration macro:
//   FETCH_PREFETCH_EN  defined   -> 2-entry FIFO, one instruction per cycle
//                                   sustained with zero-wait memory.
//                      undefined -> 1-entry FIFO, next request only after
//                                   the head pops (one instruction / 2 cycles).
//
// Parameters:
//   RESET_PC      first fetch address after reset (word aligned)
//   BUBBLE_INSTR  encoding driven on instr_o when the FIFO is empty
//
// Ports:
//   clk            clock
//   rst_n          asynchronous active-low reset
//   stall_i        hold head entry
//   redirect_i     flush FIFO, restart fetch at redirect_pc_i
//   redirect_pc_i  new fetch PC, bits [1:0] ignored
//   imem_req_o     registered read request
//   imem_addr_o    request address, stable while a request is unacked
//   imem_ack_i     request accepted, rdata valid this cycle
//   imem_rdata_i   instruction word
//   instr_o        FIFO head instruction or BUBBLE_INSTR
//   instr_valid_o  FIFO non-empty
//   pc_o           address of instr_o, holds last value when empty
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic [31:0] pc_o
);

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    // Storage is rounded up to a power of two so the pointer width always
    // matches the array index width; unused slots are never addressed.
    localparam int SLOTS = 1 << PW;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state, state_next;
    logic [31:0]   fpc, fpc_next, addr_next, last_pc, redirect_tgt;
    logic [CW-1:0] count, count_next;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          accepted, push, pop, fits;
    logic          unused_bits;

    logic [31:0] pc_mem    [SLOTS];
    logic [31:0] instr_mem [SLOTS];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    assign redirect_tgt = {redirect_pc_i[31:2], 2'b00};
    assign unused_bits  = ^redirect_pc_i[1:0];

    // Only an ack in REQ carries a word for the current stream; an ack in
    // DRAIN just retires the abandoned request.
    assign accepted = (state == S_REQ) && imem_ack_i;
    assign push     = accepted && !redirect_i;
    assign pop      = instr_valid_o && !stall_i && !redirect_i;

    always_comb begin
        count_next = count;
        if (redirect_i) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (!push && pop) begin
            count_next = count - 1'b1;
        end
    end

    assign fits = (count_next < FULL_CNT);

    always_comb begin
        fpc_next = fpc;
        if (redirect_i) begin
            fpc_next = redirect_tgt;
        end else if (accepted) begin
            fpc_next = fpc + 32'd4;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = fits ? S_REQ : S_IDLE;
            S_REQ: begin
                if (!imem_ack_i) begin
                    // Cannot withdraw an unacked request: drain it instead.
                    state_next = redirect_i ? S_DRAIN : S_REQ;
                end else begin
                    state_next = fits ? S_REQ : S_IDLE;
                end
            end
            // A redirect here only retargets fpc; the old request still
            // has to complete before the new one can be issued.
            S_DRAIN: state_next = imem_ack_i ? S_REQ : S_DRAIN;
            default: state_next = S_IDLE;
        endcase
    end

    // While draining, the bus keeps the abandoned address.
    assign addr_next = (state_next == S_DRAIN) ? imem_addr_o : fpc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            imem_req_o  <= 1'b0;
            imem_addr_o <= RESET_PC;
            fpc         <= RESET_PC;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            last_pc     <= RESET_PC;
        end else begin
            state       <= state_next;
            imem_req_o  <= (state_next != S_IDLE);
            imem_addr_o <= addr_next;
            fpc         <= fpc_next;
            count       <= count_next;
            last_pc     <= pc_o;
            if (redirect_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    // FIFO payload: no reset needed, qualified by count.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= imem_addr_o;
            instr_mem[wr_ptr] <= imem_rdata_i;
        end
    end

    assign instr_valid_o = (count != '0);
    assign instr_o       = instr_valid_o ? instr_mem[rd_ptr] : BUBBLE_INSTR;
    assign pc_o          = instr_valid_o ? pc_mem[rd_ptr] : last_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Directed bench for instr_fetch. A behavioural memory answers requests
//   with a programmable wait count and returns ~addr as the instruction word.
//   The reference model tracks, at stream level, which PC the decoder must see
//   next and which address the next accepted request must carry.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] BUBBLE = 32'h0000_0000;
`ifdef FETCH_PREFETCH_EN
    localparam int EXP_POPS = 20;
`else
    localparam int EXP_POPS = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] pc;

    int n_checks = 0;
    int n_fail   = 0;
    int mem_wait = 0;
    int wait_cnt = 0;
    bit chk_en   = 1'b0;

    instr_fetch #(
        .RESET_PC    (RST_PC),
        .BUBBLE_INSTR(BUBBLE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .imem_req_o   (req),
        .imem_addr_o  (addr),
        .imem_ack_i   (ack),
        .imem_rdata_i (rdata),
        .instr_o      (instr),
        .instr_valid_o(valid),
        .pc_o         (pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a;
    endfunction

    // Memory: ack once the request has waited mem_wait cycles.
    always_comb ack = rst_n && req && (wait_cnt >= mem_wait);
    assign rdata = mem_word(addr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          wait_cnt <= 0;
        else if (req && !ack) wait_cnt <= wait_cnt + 1;
        else                 wait_cnt <= 0;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check32(name, {31'b0, act}, {31'b0, exp});
    endtask

    // Stream-level reference model.
    logic [31:0] exp_pc  = RST_PC;
    logic [31:0] exp_req = RST_PC;
    bit          discard = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_pc  = RST_PC;
            exp_req = RST_PC;
            discard = 1'b0;
        end else if (redirect) begin
            exp_pc  = redirect_pc & 32'hFFFF_FFFC;
            exp_req = redirect_pc & 32'hFFFF_FFFC;
            discard = req && !ack;
        end else begin
            if (req && ack) begin
                if (discard) begin
                    discard = 1'b0;
                end else begin
                    check32("req_addr", addr, exp_req);
                    exp_req = exp_req + 32'd4;
                end
            end
            if (valid && !stall) exp_pc = exp_pc + 32'd4;
        end
    end

    // Per-cycle output compare.
    logic [31:0] last_seen = RST_PC;
    always @(negedge clk) begin
        if (!rst_n) begin
            last_seen = RST_PC;
        end else if (chk_en) begin
            if (valid) begin
                check32("pc_o", pc, exp_pc);
                check32("instr_o", instr, mem_word(exp_pc));
                last_seen = pc;
            end else begin
                check32("bubble", instr, BUBBLE);
                check32("pc_hold", pc, last_seen);
            end
        end
    end

    initial begin
        int          pops;
        logic [31:0] held;

        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check_bit("rst_req", req, 1'b0);
        check32("rst_addr", addr, RST_PC);
        check_bit("rst_valid", valid, 1'b0);
        check32("rst_instr", instr, BUBBLE);
        check32("rst_pc", pc, RST_PC);

        // Reset release: request rises after first edge, data one edge later.
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_bit("req_rise", req, 1'b1);
        check32("first_addr", addr, 32'h0000_0100);
        @(negedge clk);
        check_bit("first_valid", valid, 1'b1);
        check32("first_pc", pc, 32'h0000_0100);
        check32("first_instr", instr, 32'hFFFF_FEFF);

        repeat (4) @(negedge clk);
        pops = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid) pops++;
            @(negedge clk);
        end
        check32("throughput", pops, EXP_POPS);

        // Stall with valid head.
        for (int i = 0; i < 10 && !valid; i++) @(negedge clk);
        check_bit("stall_head", valid, 1'b1);
        held = pc;
        #1 stall = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check32("stall_pc", pc, held);
        end
        check_bit("stall_req_drop", req, 1'b0);
        #1 stall = 1'b0;
        mem_wait = 3;

        // Redirect while a request waits for ack -> drain.
        for (int i = 0; i < 20 && !(req && !ack); i++) @(negedge clk);
        check_bit("wait_req", req && !ack, 1'b1);
        held = addr;
        #1 redirect = 1'b1;
        redirect_pc = 32'h0000_2002;
        @(negedge clk);
        check_bit("redir_flush", valid, 1'b0);
        check_bit("drain_req", req, 1'b1);
        check32("drain_addr", addr, held);
        #1 redirect = 1'b0;
        for (int i = 0; i < 10 && !ack; i++) @(negedge clk);
        check_bit("drain_ack", ack, 1'b1);
        check32("drain_hold", addr, held);
        @(negedge clk);
        check32("post_drain_addr", addr, 32'h0000_2000);
        check_bit("drain_discard", valid, 1'b0);
        for (int i = 0; i < 10 && !valid; i++) @(negedge clk);
        check32("redir_pc", pc, 32'h0000_2000);
        check32("redir_instr", instr, 32'hFFFF_DFFF);

        // Redirect on the same edge as an ack.
        #1 mem_wait = 0;
        for (int i = 0; i < 20 && !(req && ack); i++) @(negedge clk);
        check_bit("ack_seen", req && ack, 1'b1);
        #1 redirect = 1'b1;
        redirect_pc = 32'h0000_3000;
        @(negedge clk);
        check_bit("same_req", req, 1'b1);
        check32("same_addr", addr, 32'h0000_3000);
        check_bit("same_flush", valid, 1'b0);
        #1 redirect = 1'b0;
        @(negedge clk);
        check32("same_pc", pc, 32'h0000_3000);

        // Flush wins over stall with a full FIFO.
        #1 stall = 1'b1;
        repeat (4) @(negedge clk);
        check_bit("full_valid", valid, 1'b1);
        check_bit("full_idle", req, 1'b0);
        #1 redirect = 1'b1;
        redirect_pc = 32'h0000_4000;
        @(negedge clk);
        check_bit("flush_valid", valid, 1'b0);
        check32("flush_bubble", instr, BUBBLE);
        check_bit("flush_req", req, 1'b1);
        check32("flush_addr", addr, 32'h0000_4000);
        #1 redirect = 1'b0;
        stall = 1'b0;
        repeat (3) @(negedge clk);

        // Address wrap.
        #1 redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        #1 redirect = 1'b0;
        for (int i = 0; i < 20 && !(valid && pc == 32'h0); i++) @(negedge clk);
        check_bit("wrap_seen", valid && pc == 32'h0, 1'b1);
        check32("wrap_instr", instr, 32'hFFFF_FFFF);

        // Reset pulse mid-request.
        #1 mem_wait = 3;
        for (int i = 0; i < 20 && !(req && !ack); i++) @(negedge clk);
        check_bit("mid_req", req && !ack, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check_bit("mrst_req", req, 1'b0);
        check32("mrst_addr", addr, RST_PC);
        check_bit("mrst_valid", valid, 1'b0);
        check32("mrst_instr", instr, BUBBLE);
        check32("mrst_pc", pc, RST_PC);
        @(negedge clk);
        #1 rst_n = 1'b1;
        mem_wait = 0;
        @(negedge clk);
        check_bit("rerel_req", req, 1'b1);
        check32("rerel_addr", addr, RST_PC);
        @(negedge clk);
        check32("rerel_pc", pc, RST_PC);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
